// File: rtl/fdam_dsm_pkg.sv
// Shared DSM definitions: write-server FSM encodings and {data, addr, tag} word layout helpers.
package fdam_dsm_pkg;

  typedef enum logic [1:0] {
    DSM_SRV_RUN   = 2'b00,
    DSM_SRV_DRAIN = 2'b01
  } dsm_srv_state_e;

  // The tag sits in the LSBs, then the address, then the data.
  function automatic int unsigned dsm_tag_lsb();
    return 0;
  endfunction

  function automatic int unsigned dsm_addr_lsb(input int unsigned tag_w);
    return tag_w;
  endfunction

  function automatic int unsigned dsm_data_lsb(input int unsigned tag_w,
                                               input int unsigned addr_w);
    return tag_w + addr_w;
  endfunction

  function automatic int unsigned dsm_word_width(input int unsigned data_w,
                                                 input int unsigned addr_w,
                                                 input int unsigned tag_w);
    return data_w + addr_w + tag_w;
  endfunction

endpackage

// File: rtl/fdam_sync_fifo.sv
// Single-clock FIFO whose head is read straight out of the storage flops; supports push and pop in one cycle.
module fdam_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     occ,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == DEPTH_C);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign occ     = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fdam_dsm_write_server.sv
// DSM status-write responder: buffers controller line writes, issues them to memory under an
// outstanding-write cap, forwards completions and supports a flush/drain handshake.
module fdam_dsm_write_server
  import fdam_dsm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned TAG_WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       request_write,
  input  logic [DATA_WIDTH+ADDR_WIDTH+TAG_WIDTH-1:0] write_data,
  output logic                                       available_write,
  output logic                                       write_data_valid,
  output logic [TAG_WIDTH-1:0]                       write_queue_id,
  output logic                                       mem_wr_valid,
  input  logic                                       mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]                      mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                      mem_wr_data,
  output logic [TAG_WIDTH-1:0]                       mem_wr_tag,
  input  logic                                       mem_wr_rsp_valid,
  input  logic [TAG_WIDTH-1:0]                       mem_wr_rsp_tag,
  input  logic                                       flush,
  output logic                                       flush_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
  output logic                                       overflow
);

  localparam int unsigned WORD_W   = dsm_word_width(DATA_WIDTH, ADDR_WIDTH, TAG_WIDTH);
  localparam int unsigned TAG_LSB  = dsm_tag_lsb();
  localparam int unsigned ADDR_LSB = dsm_addr_lsb(TAG_WIDTH);
  localparam int unsigned DATA_LSB = dsm_data_lsb(TAG_WIDTH, ADDR_WIDTH);
  localparam int unsigned OCCW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUTW     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OCCW:0]   DEPTH_C   = (OCCW + 1)'(FIFO_DEPTH);
  localparam logic [OUTW-1:0] MAX_OUT_C = OUTW'(MAX_OUTSTANDING);

  dsm_srv_state_e state_q, state_d;

  logic [WORD_W-1:0] head;
  logic [OCCW-1:0]   occ;
  logic              full;
  logic              empty;
  logic              xfer;
  logic              out_zero;
  logic              drain_done;
  logic [OCCW:0]     occ_next_req;
  logic [OUTW-1:0]   outstanding_q;

  fdam_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (request_write),
    .pop   (xfer),
    .din   (write_data),
    .head  (head),
    .occ   (occ),
    .full  (full),
    .empty (empty)
  );

  assign outstanding = outstanding_q;
  assign out_zero    = (outstanding_q == '0);

  assign mem_wr_valid = ~empty & (outstanding_q < MAX_OUT_C);
  assign xfer         = mem_wr_valid & mem_wr_ready;
  assign mem_wr_tag   = head[TAG_LSB  +: TAG_WIDTH];
  assign mem_wr_addr  = head[ADDR_LSB +: ADDR_WIDTH];
  assign mem_wr_data  = head[DATA_LSB +: DATA_WIDTH];

  // Counting the current request keeps one slot of slack for the controller's registered reaction.
  assign occ_next_req    = {1'b0, occ} + {{OCCW{1'b0}}, request_write};
  assign available_write = ~rst & (state_q == DSM_SRV_RUN) & (occ_next_req < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      DSM_SRV_RUN: begin
        if (flush) state_d = DSM_SRV_DRAIN;
      end
      DSM_SRV_DRAIN: begin
        if (empty && out_zero) begin
          drain_done = 1'b1;
          state_d    = DSM_SRV_RUN;
        end
      end
      default: state_d = DSM_SRV_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DSM_SRV_RUN;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_done <= drain_done;
    end
  end

  // A completion with nothing outstanding does not underflow the count; it still cancels nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      case ({xfer, mem_wr_rsp_valid & ~out_zero})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_data_valid <= 1'b0;
      write_queue_id   <= '0;
    end else begin
      write_data_valid <= mem_wr_rsp_valid;
      if (mem_wr_rsp_valid) write_queue_id <= mem_wr_rsp_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((request_write & full & ~xfer) | (mem_wr_rsp_valid & out_zero)) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fdam_dsm_write_server.sv
// Randomized bench for fdam_dsm_write_server, checked every cycle against a queue-based reference model.
module tb_fdam_dsm_write_server;

  localparam int DW    = 512;
  localparam int AW    = 48;
  localparam int TW    = 16;
  localparam int DEPTH = 8;
  localparam int MAXO  = 16;
  localparam int WW    = DW + AW + TW;
  localparam int OW    = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          request_write;
  logic [WW-1:0] write_data;
  logic          available_write;
  logic          write_data_valid;
  logic [TW-1:0] write_queue_id;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [TW-1:0] mem_wr_tag;
  logic          mem_wr_rsp_valid;
  logic [TW-1:0] mem_wr_rsp_tag;
  logic          flush;
  logic          flush_done;
  logic [OW-1:0] outstanding;
  logic          overflow;

  always #5 clk = ~clk;

  fdam_dsm_write_server #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .TAG_WIDTH       (TW),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .request_write    (request_write),
    .write_data       (write_data),
    .available_write  (available_write),
    .write_data_valid (write_data_valid),
    .write_queue_id   (write_queue_id),
    .mem_wr_valid     (mem_wr_valid),
    .mem_wr_ready     (mem_wr_ready),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_tag       (mem_wr_tag),
    .mem_wr_rsp_valid (mem_wr_rsp_valid),
    .mem_wr_rsp_tag   (mem_wr_rsp_tag),
    .flush            (flush),
    .flush_done       (flush_done),
    .outstanding      (outstanding),
    .overflow         (overflow)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [WW-1:0] mq[$];
  logic [TW-1:0] pend[$];
  int            m_out   = 0;
  bit            m_ovf   = 0;
  bit            m_drain = 0;
  bit            m_wdv   = 0;
  bit            m_fd    = 0;
  logic [TW-1:0] m_wqid  = '0;
  logic [AW-1:0] next_addr = 48'h2000;

  task automatic cycle();
    bit exp_avail, exp_valid, xfer, done;
    int sz;
    @(negedge clk);
    sz        = mq.size();
    exp_avail = !rst && !m_drain && (sz + int'(request_write)) < DEPTH;
    exp_valid = sz > 0 && m_out < MAXO;
    chk("available_write", WW'(available_write), WW'(exp_avail));
    chk("mem_wr_valid", WW'(mem_wr_valid), WW'(exp_valid));
    if (exp_valid) begin
      chk("mem_wr_tag", WW'(mem_wr_tag), WW'(mq[0][TW-1:0]));
      chk("mem_wr_addr", WW'(mem_wr_addr), WW'(mq[0][TW +: AW]));
      chk("mem_wr_data", WW'(mem_wr_data), WW'(mq[0][TW+AW +: DW]));
    end
    chk("write_data_valid", WW'(write_data_valid), WW'(m_wdv));
    if (m_wdv) chk("write_queue_id", WW'(write_queue_id), WW'(m_wqid));
    chk("flush_done", WW'(flush_done), WW'(m_fd));
    chk("overflow", WW'(overflow), WW'(m_ovf));
    chk("outstanding", WW'(outstanding), WW'(m_out));

    xfer = exp_valid && mem_wr_ready;
    if (rst) begin
      mq.delete();
      m_out = 0; m_ovf = 0; m_drain = 0; m_wdv = 0; m_fd = 0; m_wqid = '0;
    end else begin
      done = m_drain && sz == 0 && m_out == 0;
      m_fd = done;
      if (!m_drain && flush) m_drain = 1;
      else if (done)         m_drain = 0;
      if (request_write && sz == DEPTH && !xfer) m_ovf = 1;
      if (mem_wr_rsp_valid && m_out == 0)        m_ovf = 1;
      m_out = m_out + (xfer ? 1 : 0) - ((mem_wr_rsp_valid && m_out > 0) ? 1 : 0);
      if (xfer) begin
        pend.push_back(mq[0][TW-1:0]);
        void'(mq.pop_front());
      end
      if (request_write && (sz < DEPTH || xfer)) mq.push_back(write_data);
      m_wdv = mem_wr_rsp_valid;
      if (mem_wr_rsp_valid) m_wqid = mem_wr_rsp_tag;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return {d, next_addr, TW'($urandom)};
  endfunction

  // Percent probabilities; gate makes the requester honour the one-cycle-ahead availability.
  task automatic drive_rand(input int p_req, input bit gate, input int p_rdy,
                            input int p_rsp, input int p_flush);
    request_write = (int'($urandom_range(99)) < p_req) &&
                    (!gate || ((mq.size() + 1) < DEPTH && !m_drain));
    write_data    = rand_word();
    if (request_write) next_addr = next_addr + 48'd64;
    mem_wr_ready  = int'($urandom_range(99)) < p_rdy;
    if (pend.size() > 0 && int'($urandom_range(99)) < p_rsp) begin
      mem_wr_rsp_valid = 1'b1;
      mem_wr_rsp_tag   = pend.pop_front();
    end else begin
      mem_wr_rsp_valid = 1'b0;
      mem_wr_rsp_tag   = TW'($urandom);
    end
    flush = int'($urandom_range(99)) < p_flush;
  endtask

  task automatic run(input int n, input int p_req, input bit gate, input int p_rdy,
                     input int p_rsp, input int p_flush);
    for (int i = 0; i < n; i++) begin
      drive_rand(p_req, gate, p_rdy, p_rsp, p_flush);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; request_write = 1'b0; write_data = '0; mem_wr_ready = 1'b0;
    mem_wr_rsp_valid = 1'b0; mem_wr_rsp_tag = '0; flush = 1'b0;
    #1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Single write with a known pattern
    request_write = 1'b1;
    write_data    = {{64{8'hA5}}, 48'h1000, 16'h8001};
    mem_wr_ready  = 1'b1;
    cycle();
    request_write = 1'b0;
    cycle();
    mem_wr_rsp_valid = 1'b1;
    mem_wr_rsp_tag   = pend.pop_front();
    cycle();
    mem_wr_rsp_valid = 1'b0;
    cycle();
    chk("single_id", WW'(write_queue_id), WW'(16'h8001));
    chk("single_outst", WW'(outstanding), '0);

    // Backpressure, then release
    run(12, 100, 1, 0, 0, 0);
    chk("bp_no_ovf", WW'(overflow), '0);
    run(12, 0, 1, 100, 100, 0);

    // Outstanding cap
    run(24, 100, 1, 100, 0, 0);
    chk("cap_outst", WW'(outstanding), WW'(MAXO));
    chk("cap_valid_low", WW'(mem_wr_valid), '0);
    run(40, 0, 1, 100, 70, 0);

    // Flush with work buffered and in flight
    run(6, 100, 1, 50, 0, 0);
    flush = 1'b1; request_write = 1'b0; mem_wr_rsp_valid = 1'b0;
    cycle();
    run(60, 30, 1, 60, 50, 0);

    // Mixed random traffic with occasional flushes
    run(400, 60, 1, 70, 40, 3);

    // Reset mid-burst with writes in flight; late completions follow
    run(4, 100, 1, 100, 0, 0);
    run(4, 100, 1, 0, 0, 0);
    rst = 1'b1; request_write = 1'b0; mem_wr_rsp_valid = 1'b0; flush = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_outst", WW'(outstanding), '0);
    run(50, 50, 1, 70, 60, 0);

    // Forced overflow after a clean reset
    rst = 1'b1; request_write = 1'b0; mem_wr_rsp_valid = 1'b0;
    cycle();
    rst = 1'b0;
    pend.delete();
    cycle();
    chk("pre_ovf_clear", WW'(overflow), '0);
    run(10, 100, 0, 0, 0, 0);
    chk("ovf_set", WW'(overflow), WW'(1'b1));
    run(40, 0, 1, 100, 80, 0);
    chk("ovf_sticky", WW'(overflow), WW'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
